// File: rtl/warp_lsu_pkg.sv
// warp_lsu_pkg: shared warp pipeline / LSU types and memory request widths
// Provides warp_state_t, lsu_state_t and the memory request width constants.
// The DATA_WIDTH macro defaults to 16 when the build does not define it.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
package warp_lsu_pkg;
    localparam int MEM_ADDR_WIDTH = `DATA_WIDTH;
    localparam int MEM_DATA_WIDTH = `DATA_WIDTH;
    typedef enum logic [2:0] {
        WARP_IDLE, WARP_FETCH, WARP_DECODE, WARP_REQUEST,
        WARP_WAIT, WARP_EXECUTE, WARP_UPDATE, WARP_DONE
    } warp_state_t;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} lsu_state_t;
endpackage

// File: rtl/warp_lsu_next_thread.sv
// lsu_next_thread: lowest-index priority encoder over the pending-thread mask
// Ports: pending (mask in), index (lowest set bit), any (mask non-zero).
module lsu_next_thread #(
    parameter int THREADS = 16,
    parameter int IDX_W = 4
) (
    input  logic [THREADS-1:0] pending,
    output logic [IDX_W-1:0]   index,
    output logic               any
);
    always_comb begin
        index = '0;
        any = |pending;
        for (int i = THREADS - 1; i >= 0; i--)
            if (pending[i]) index = IDX_W'(i);
    end
endmodule

// File: rtl/warp_lsu.sv
// warp_lsu: per-warp load/store unit, one memory request outstanding at a time
// Ports: clk/reset (sync, active high), enable (freeze when low), thread_enable,
// warp_state, decoded load/store/immediate, rs1/rs2 (flat per-thread vectors),
// mem read/write valid-ready channels, lsu_out (flat per-thread), lsu_done.
// Optional macro LSU_COALESCE_EN: one load answers every pending thread with
// the same captured address.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
module warp_lsu
    import warp_lsu_pkg::*;
#(
    parameter int THREADS_PER_WARP = 16,
    parameter int DATA_WIDTH = `DATA_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   enable,
    input  logic [THREADS_PER_WARP-1:0]            thread_enable,
    input  warp_state_t                            warp_state,
    input  logic                                   decoded_mem_read_enable,
    input  logic                                   decoded_mem_write_enable,
    input  logic [DATA_WIDTH-1:0]                  decoded_immediate,
    input  logic [THREADS_PER_WARP*DATA_WIDTH-1:0] rs1,
    input  logic [THREADS_PER_WARP*DATA_WIDTH-1:0] rs2,
    output logic                                   mem_read_valid,
    output logic [DATA_WIDTH-1:0]                  mem_read_address,
    input  logic                                   mem_read_ready,
    input  logic [DATA_WIDTH-1:0]                  mem_read_data,
    output logic                                   mem_write_valid,
    output logic [DATA_WIDTH-1:0]                  mem_write_address,
    output logic [DATA_WIDTH-1:0]                  mem_write_data,
    input  logic                                   mem_write_ready,
    output logic [THREADS_PER_WARP*DATA_WIDTH-1:0] lsu_out,
    output logic                                   lsu_done
);
    localparam int T = THREADS_PER_WARP;
    localparam int IW = T > 1 ? $clog2(T) : 1;
    lsu_state_t state, next_state;
    logic [T-1:0] pending, done_mask;
    logic [DATA_WIDTH-1:0] addr_q [T];
    logic [DATA_WIDTH-1:0] data_q [T];
    logic [IW-1:0] cur, sel;
    logic is_read, any, ready, start;
    lsu_next_thread #(.THREADS(T), .IDX_W(IW)) u_next (.pending(pending), .index(sel), .any(any));
    assign start = warp_state == WARP_WAIT && (decoded_mem_read_enable || decoded_mem_write_enable);
    assign ready = is_read ? mem_read_ready : mem_write_ready;
    assign lsu_done = state == DONE;
    // Threads retired by the current response.
    always_comb begin
        done_mask = '0;
        done_mask[cur] = 1'b1;
`ifdef LSU_COALESCE_EN
        for (int j = 0; j < T; j++)
            if (is_read && pending[j] && addr_q[j] == addr_q[cur]) done_mask[j] = 1'b1;
`endif
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = |thread_enable ? ISSUE : DONE;
            ISSUE: next_state = any ? WAIT : DONE;
            WAIT:  if (ready) next_state = |(pending & ~done_mask) ? ISSUE : DONE;
            DONE:  if (warp_state == WARP_UPDATE) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else if (enable) state <= next_state;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            is_read <= 1'b0;
            cur <= '0;
            mem_read_valid <= 1'b0;
            mem_write_valid <= 1'b0;
            mem_read_address <= '0;
            mem_write_address <= '0;
            mem_write_data <= '0;
            lsu_out <= '0;
            for (int i = 0; i < T; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (enable) begin
            if (state == IDLE && next_state == ISSUE) begin
                pending <= thread_enable;
                is_read <= decoded_mem_read_enable;
                for (int i = 0; i < T; i++) begin
                    addr_q[i] <= rs1[i*DATA_WIDTH +: DATA_WIDTH] + decoded_immediate;
                    data_q[i] <= rs2[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            if (state == ISSUE && any) begin
                cur <= sel;
                mem_read_valid <= is_read;
                mem_write_valid <= !is_read;
                if (is_read) mem_read_address <= addr_q[sel];
                else begin
                    mem_write_address <= addr_q[sel];
                    mem_write_data <= data_q[sel];
                end
            end
            if (state == WAIT && ready) begin
                mem_read_valid <= 1'b0;
                mem_write_valid <= 1'b0;
                pending <= pending & ~done_mask;
                for (int j = 0; j < T; j++)
                    if (is_read && done_mask[j]) lsu_out[j*DATA_WIDTH +: DATA_WIDTH] <= mem_read_data;
            end
        end
    end
endmodule

// File: tb/tb_warp_lsu.sv
// tb_warp_lsu: table, directed and random checks of warp_lsu against a request-list model
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
module tb_warp_lsu;
    import warp_lsu_pkg::*;
    localparam int T = 16;
    localparam int DW = 16;
`ifdef LSU_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif
    typedef struct {
        logic [T-1:0] mask;
        bit rd;
        bit wr;
        logic [DW-1:0] imm;
        logic [DW-1:0] base;
        logic [DW-1:0] stride;
        int lat;
        int reqs;
        int cycles;
    } vec_t;
    typedef struct {
        bit wr;
        logic [DW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;
    logic clk = 1'b0, reset = 1'b1, enable = 1'b1;
    logic [T-1:0] thread_enable = '0;
    warp_state_t warp_state = WARP_IDLE;
    logic rd_en = 1'b0, wr_en = 1'b0;
    logic [DW-1:0] decoded_immediate = '0;
    logic [T*DW-1:0] rs1 = '0, rs2 = '0, lsu_out;
    logic mem_read_valid, mem_write_valid, mem_read_ready, mem_write_ready, lsu_done;
    logic [DW-1:0] mem_read_address, mem_write_address, mem_write_data;
    logic [DW-1:0] mem_read_data = '0;
    logic resp_en = 1'b0, resp_rdy = 1'b0, man_rdy = 1'b0;
    int lat_cfg = 0;
    req_t log_q[$];
    logic [DW-1:0] rs1_v [T];
    logic [DW-1:0] rs2_v [T];
    logic [DW-1:0] exp_out [T];
    int passed = 0, total = 0;
    assign mem_read_ready = resp_en ? resp_rdy : man_rdy;
    assign mem_write_ready = resp_en ? resp_rdy : man_rdy;
    always #5 clk = ~clk;
    warp_lsu #(.THREADS_PER_WARP(T), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .thread_enable(thread_enable),
        .warp_state(warp_state), .decoded_mem_read_enable(rd_en),
        .decoded_mem_write_enable(wr_en), .decoded_immediate(decoded_immediate),
        .rs1(rs1), .rs2(rs2), .mem_read_valid(mem_read_valid),
        .mem_read_address(mem_read_address), .mem_read_ready(mem_read_ready),
        .mem_read_data(mem_read_data), .mem_write_valid(mem_write_valid),
        .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
        .mem_write_ready(mem_write_ready), .lsu_out(lsu_out), .lsu_done(lsu_done)
    );
    function automatic logic [DW-1:0] mem_f(input logic [DW-1:0] a);
        return (a * 16'd7) ^ 16'h5A3C;
    endfunction
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    task automatic check_out(input string tag);
        for (int i = 0; i < T; i++)
            check($sformatf("%s lsu_out[%0d]", tag, i), 64'(lsu_out[i*DW +: DW]), 64'(exp_out[i]));
    endtask
    // Memory responder: ready after lat_cfg waiting cycles, logs each accepted handshake.
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(negedge clk);
            mem_read_data = mem_f(mem_read_address);
            if (resp_en && enable && (mem_read_valid || mem_write_valid)) begin
                if (wcnt >= lat_cfg) begin
                    resp_rdy = 1'b1;
                    wcnt = 0;
                    log_q.push_back('{mem_write_valid, mem_write_valid ? mem_write_address : mem_read_address,
                                      mem_write_valid ? mem_write_data : '0});
                end else begin
                    resp_rdy = 1'b0;
                    wcnt++;
                end
            end else begin
                resp_rdy = 1'b0;
                wcnt = 0;
            end
        end
    end
    task automatic start_op(input logic [T-1:0] m, input bit r, input bit w, input logic [DW-1:0] im);
        thread_enable = m;
        rd_en = r;
        wr_en = w;
        decoded_immediate = im;
        for (int i = 0; i < T; i++) begin
            rs1[i*DW +: DW] = rs1_v[i];
            rs2[i*DW +: DW] = rs2_v[i];
        end
        warp_state = WARP_WAIT;
        @(posedge clk);
        #1;
        warp_state = WARP_EXECUTE;
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask
    // Expected traffic: active threads in ascending order; a load is skipped when
    // coalescing and an earlier active thread already asked for the same address.
    task automatic run_op(input string tag, input logic [T-1:0] m, input bit r, input bit w,
                          input logic [DW-1:0] im, input int lat, input int tab_reqs, input int tab_cyc);
        req_t exp_q[$];
        logic [DW-1:0] seen[$];
        logic [DW-1:0] ad;
        int base, cnt, n;
        bit dup;
        for (int i = 0; i < T; i++) begin
            if (m[i]) begin
                ad = rs1_v[i] + im;
                if (r) begin
                    dup = 1'b0;
                    foreach (seen[k]) if (seen[k] == ad) dup = 1'b1;
                    if (!(COAL && dup)) exp_q.push_back('{1'b0, ad, '0});
                    seen.push_back(ad);
                    exp_out[i] = mem_f(ad);
                end else exp_q.push_back('{1'b1, ad, rs2_v[i]});
            end
        end
        base = log_q.size();
        lat_cfg = lat;
        resp_en = 1'b1;
        start_op(m, r, w, im);
        cnt = 0;
        while (cnt < 1000) begin
            @(negedge clk);
            if (lsu_done) break;
            cnt++;
        end
        check({tag, " done reached"}, 64'(lsu_done), 64'd1);
        check({tag, " cycles"}, 64'(cnt), 64'(tab_cyc >= 0 ? tab_cyc : exp_q.size() * (lat + 2)));
        n = log_q.size() - base;
        check({tag, " request count"}, 64'(n), 64'(exp_q.size()));
        if (tab_reqs >= 0) check({tag, " table request count"}, 64'(n), 64'(tab_reqs));
        for (int k = 0; k < n && k < exp_q.size(); k++)
            check($sformatf("%s req %0d", tag, k),
                  {31'd0, log_q[base+k].wr, log_q[base+k].addr, log_q[base+k].data},
                  {31'd0, exp_q[k].wr, exp_q[k].addr, exp_q[k].data});
        check_out(tag);
        @(negedge clk);
        check({tag, " done held, no valid"}, {62'd0, lsu_done, mem_read_valid | mem_write_valid}, 64'd2);
        resp_en = 1'b0;
        warp_state = WARP_UPDATE;
        @(posedge clk);
        #1;
        warp_state = WARP_EXECUTE;
        @(negedge clk);
        check({tag, " back to idle"}, 64'(lsu_done), 64'd0);
    endtask
    initial begin
        vec_t vecs [6];
        logic [T-1:0] m;
        logic [DW-1:0] im;
        bit r, w;
        vecs[0] = '{16'h0005, 1'b1, 1'b0, 16'h0004, 16'h0100, 16'h0080, 1, 2, 6};
        vecs[1] = '{16'hFFFF, 1'b0, 1'b1, 16'h0008, 16'h0300, 16'h0002, 0, 16, 32};
        vecs[2] = '{16'h0000, 1'b1, 1'b0, 16'h0004, 16'h0100, 16'h0010, 0, 0, 0};
        vecs[3] = '{16'h8001, 1'b1, 1'b1, 16'h0010, 16'h0400, 16'h0004, 2, 2, 8};
        vecs[4] = '{16'h000F, 1'b1, 1'b0, 16'h0000, 16'h0040, 16'h0000, 0, COAL ? 1 : 4, COAL ? 2 : 8};
        vecs[5] = '{16'h0A50, 1'b0, 1'b1, 16'hFFF0, 16'hFF00, 16'h0010, 3, 4, 20};
        for (int i = 0; i < T; i++) exp_out[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset valids/done", {61'd0, mem_read_valid, mem_write_valid, lsu_done}, 64'd0);
        check("reset addresses/data", {16'd0, mem_read_address, mem_write_address, mem_write_data}, 64'd0);
        check_out("reset");
        reset = 1'b0;
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < T; i++) begin
                rs1_v[i] = vecs[v].base + vecs[v].stride * 16'(i);
                rs2_v[i] = 16'(i);
            end
            run_op($sformatf("vec%0d", v), vecs[v].mask, vecs[v].rd, vecs[v].wr, vecs[v].imm,
                   vecs[v].lat, vecs[v].reqs, vecs[v].cycles);
        end
        // Long wait with enable low mid-wait and spurious ready pulses.
        for (int i = 0; i < T; i++) rs1_v[i] = 16'h0500 + 16'(i);
        rs1_v[1] = 16'h0500;
        man_rdy = 1'b0;
        start_op(16'h0002, 1'b1, 1'b0, 16'h0000);
        @(negedge clk);
        man_rdy = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check($sformatf("stall valid k%0d", k), {47'd0, mem_read_valid, mem_read_address}, {47'd0, 1'b1, 16'h0500});
            enable = !(k == 2 || k == 3);
            man_rdy = (k == 3 || k == 6);
        end
        @(negedge clk);
        man_rdy = 1'b0;
        exp_out[1] = mem_f(16'h0500);
        check("stall completion", {62'd0, mem_read_valid, lsu_done}, 64'd1);
        check_out("stall");
        repeat (2) @(negedge clk);
        check("stall single completion", {62'd0, mem_read_valid, lsu_done}, 64'd1);
        warp_state = WARP_UPDATE;
        @(posedge clk);
        #1;
        warp_state = WARP_EXECUTE;
        @(negedge clk);
        check("stall back to idle", 64'(lsu_done), 64'd0);
        // Randomized traffic against the request-list model.
        for (int n = 0; n < 24; n++) begin
            m = ($urandom_range(0, 7) == 0) ? '0 : T'($urandom);
            r = 1'($urandom_range(0, 1));
            w = r ? 1'($urandom_range(0, 1)) : 1'b1;
            im = 16'($urandom);
            for (int i = 0; i < T; i++) begin
                rs1_v[i] = 16'h2000 + 16'($urandom_range(0, 3)) * 16'd4;
                rs2_v[i] = 16'($urandom);
            end
            run_op($sformatf("rand%0d", n), m, r, w, im, $urandom_range(0, 3), -1, -1);
        end
        // Reset while a load waits for ready; a late ready must not matter.
        rs1_v[0] = 16'h0700;
        man_rdy = 1'b0;
        start_op(16'h0001, 1'b1, 1'b0, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        check("pre-reset request", {47'd0, mem_read_valid, mem_read_address}, {47'd0, 1'b1, 16'h0700});
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < T; i++) exp_out[i] = '0;
        check("reset abort", {45'd0, mem_read_valid, lsu_done, 1'b0, mem_read_address}, 64'd0);
        check_out("reset abort");
        man_rdy = 1'b1;
        repeat (2) @(negedge clk);
        man_rdy = 1'b0;
        check("late ready ignored", {62'd0, mem_read_valid, lsu_done}, 64'd0);
        check_out("late ready");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
